axi4_interconnect_wr_addr_arbiter: RTL and testbench
====================================================

// Module: axi4_interconnect_wr_addr_arbiter
// PURPOSE
//  Arbitrates the AXI4 write-address (AW) channel between masters M0/M1 and routes each
//  request to one of 4 slaves, decoded from AWADDR[AWIDTH-1:AWIDTH-2].
//  Stores each accepted address in a per-master FIFO.
//  Drives wrDataChanAddr so the write-data channel routes every beat of the burst to the
//  same slave; pops the FIFO entry when the burst's last beat completes.
// PARAMETERS
//  AWIDTH     32  address width in bits; the top 2 bits select the slave
//  FIFO_DEPTH 4   outstanding bursts per master (power of 2, >=2)
// PORTS
//  clock            in   1       single clock, rising edge
//  resetn           in   1       asynchronous, active-low reset
//  AWVALID_M0/M1    in   1       master address valid
//  AWADDR_M0/M1     in   AWIDTH  master address
//  AWLEN_M0/M1      in   8       burst length - 1
//  AWREADY_M0/M1    out  1       one-cycle accept pulse to the master
//  AWVALID_S0..S3   out  1       per-slave address valid
//  AWADDR_S         out  AWIDTH  shared address bus to all slaves
//  AWLEN_S          out  8       shared burst length to all slaves
//  AWREADY_S0..S3   in   1       per-slave address ready
//  wrDataChanGrant  in   2       data-channel grant: 01=M0, 10=M1, 00=none
//  wrLastDone       in   1       slave-side WVALID&WREADY&WLAST of the granted burst
//  wrDataChanAddr   out  AWIDTH  head-of-FIFO address for the granted master; 0 if none
// BEHAVIOUR
//  Reset values
//   - All outputs 0; FSM in M0_PRI_IDLE; FIFO pointers and counts 0.
//  FSM (one-hot)
//   - States: M0_PRI_IDLE, M1_PRI_IDLE, M0_ISSUE, M1_ISSUE.
//   - Mx_PRI_IDLE: Mx has priority. A master is eligible when AWVALID_Mx=1 and its FIFO is not full.
//   - Priority master eligible -> Mx_ISSUE; else the other master eligible -> its ISSUE state; else stay.
//   - On entry to Mx_ISSUE (registered), in the same edge:
//     * AWADDR_S/AWLEN_S latch Mx's AWADDR/AWLEN.
//     * AWVALID_Sk=1 for k = AWADDR[AWIDTH-1:AWIDTH-2].
//   - Mx_ISSUE, on AWVALID_Sk&AWREADY_Sk:
//     * Clear AWVALID_Sk at the next edge.
//     * Pulse AWREADY_Mx for 1 cycle.
//     * Push the latched address into FIFO_x.
//     * Go to the other master's PRI_IDLE (round robin).
//  Latency
//   - AWVALID_Mx to AWVALID_Sk: 1 cycle when idle.
//   - Slave handshake to AWREADY_Mx: 1 cycle.
//  Handshake rules
//   - A master is never re-granted while its AWREADY_Mx pulse is high.
//   - AWVALID_Sk stays high until AWREADY_Sk is seen; AWADDR_S/AWLEN_S hold stable meanwhile.
//   - At most one AWVALID_Sk is high at any time.
//  FIFOs
//   - Pop FIFO_x when wrLastDone=1 and wrDataChanGrant selects x.
//   - Push and pop in the same cycle: count unchanged, both pointers advance.
//   - Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
//   - Full FIFO: that master is not eligible; the other master can still win.
//   - Pop on an empty FIFO is ignored and fires assertion a_pop_empty (sim only).
//   - wrDataChanAddr is combinational from the head of the granted FIFO; it reads 0 when
//     the FIFO is empty or the grant is 00/11.
//  Reset mid-operation
//   - All state clears immediately; outstanding entries are discarded.
//   - No AWREADY pulse is emitted after reset is released.
// STRUCTURE
//  Shared package axi4_ic_pkg:
//   - FSM one-hot localparams.
//   - SLV_SEL_MSB/LSB decode constants.
//   - GRANT_M0=2'b01, GRANT_M1=2'b10.
//  Sub-module axi4_ic_addr_fifo (AWIDTH x FIFO_DEPTH; push, pop, full, empty, head):
//   - instantiated twice;
//   - FSM, decode and output registers stay in the top level.
// TESTING
//  1. Reset, then AWVALID_M0=1, AWADDR_M0=0x4000_0010
//     -> AWVALID_S1=1 on the next edge, AWADDR_S=0x4000_0010.
//     -> AWREADY_S1=1 gives an AWREADY_M0 pulse 1 cycle later.
//  2. M0 and M1 both valid continuously (addrs 0x0..., 0xC...)
//     -> order M0,M1,M0,M1; AWVALID_S0 and AWVALID_S3 alternate; never both high.
//  3. Fill FIFO_0 with 4 bursts with no wrLastDone
//     -> 5th M0 request stalls and M1 is still served.
//     -> wrLastDone with grant=01 frees the slot and M0 issues next.
//  4. Push and pop on FIFO_1 in the same cycle at count=2
//     -> count stays 2; wrDataChanAddr advances to the next head.
//  5. Assert resetn=0 while AWVALID_S2=1 and FIFO_0 count=3
//     -> all outputs 0 asynchronously; after release wrDataChanAddr=0 and the FSM is in
//        M0_PRI_IDLE.

Source files
------------

// File: rtl/axi4_ic_pkg.sv
// rtl/axi4_ic_pkg.sv - shared types and constants for the AXI4 write-address arbiter
// Purpose: one-hot FSM encoding, slave-select field position, data-channel grant codes.
// Ports: none (package).
package axi4_ic_pkg;

  // One-hot arbiter states; PRI_IDLE names which master currently holds priority.
  typedef enum logic [3:0] {
    M0_PRI_IDLE = 4'b0001,
    M1_PRI_IDLE = 4'b0010,
    M0_ISSUE    = 4'b0100,
    M1_ISSUE    = 4'b1000
  } aw_state_e;

  // Slave-select field, counted down from the address width:
  // addr[AWIDTH-SLV_SEL_MSB : AWIDTH-SLV_SEL_LSB] keeps the decode valid for any AWIDTH.
  localparam int SLV_SEL_MSB = 1;
  localparam int SLV_SEL_LSB = 2;

  localparam logic [1:0] GRANT_M0 = 2'b01;
  localparam logic [1:0] GRANT_M1 = 2'b10;

  function automatic logic [3:0] slave_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/axi4_ic_addr_fifo.sv
// rtl/axi4_ic_addr_fifo.sv - per-master FIFO of issued burst addresses
// Purpose: holds the address of every accepted burst until its last data beat completes.
// Ports: clock, resetn (async, active-low); push/push_data write an entry;
//        pop drops the head; full/empty status; head is the oldest entry.
module axi4_ic_addr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // A pop with nothing stored is dropped rather than corrupting the pointers.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  a_pop_empty: assert property (@(posedge clock) disable iff (!resetn) !(pop && empty));

endmodule

// File: rtl/axi4_interconnect_wr_addr_arbiter.sv
// rtl/axi4_interconnect_wr_addr_arbiter.sv - AW channel arbiter for 2 masters and 4 slaves
// Purpose: round-robin arbitration of M0/M1 write addresses, slave decode from the top
//          two address bits, and per-master address FIFOs that steer the data channel.
// Ports: clock, resetn (async, active-low);
//        AWVALID/AWADDR/AWLEN_M0/M1 in, AWREADY_M0/M1 out (one-cycle accept pulse);
//        AWVALID_S0..S3, AWADDR_S, AWLEN_S out, AWREADY_S0..S3 in;
//        wrDataChanGrant, wrLastDone in; wrDataChanAddr out (head of granted FIFO).
module axi4_interconnect_wr_addr_arbiter
  import axi4_ic_pkg::*;
#(
  parameter int AWIDTH     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              AWVALID_M0,
  input  logic [AWIDTH-1:0] AWADDR_M0,
  input  logic [7:0]        AWLEN_M0,
  output logic              AWREADY_M0,
  input  logic              AWVALID_M1,
  input  logic [AWIDTH-1:0] AWADDR_M1,
  input  logic [7:0]        AWLEN_M1,
  output logic              AWREADY_M1,
  output logic              AWVALID_S0,
  output logic              AWVALID_S1,
  output logic              AWVALID_S2,
  output logic              AWVALID_S3,
  output logic [AWIDTH-1:0] AWADDR_S,
  output logic [7:0]        AWLEN_S,
  input  logic              AWREADY_S0,
  input  logic              AWREADY_S1,
  input  logic              AWREADY_S2,
  input  logic              AWREADY_S3,
  input  logic [1:0]        wrDataChanGrant,
  input  logic              wrLastDone,
  output logic [AWIDTH-1:0] wrDataChanAddr
);

  aw_state_e         state;
  aw_state_e         state_next;
  logic [3:0]        awvalid_s;
  logic              elig0, elig1, slv_hs;
  logic              load0, load1, push0, push1, pop0, pop1;
  logic              full0, full1, empty0, empty1;
  logic [AWIDTH-1:0] head0, head1;
  logic [1:0]        sel0, sel1;

  assign sel0 = AWADDR_M0[AWIDTH-SLV_SEL_MSB : AWIDTH-SLV_SEL_LSB];
  assign sel1 = AWADDR_M1[AWIDTH-SLV_SEL_MSB : AWIDTH-SLV_SEL_LSB];

  assign AWVALID_S0 = awvalid_s[0];
  assign AWVALID_S1 = awvalid_s[1];
  assign AWVALID_S2 = awvalid_s[2];
  assign AWVALID_S3 = awvalid_s[3];

  assign pop0 = wrLastDone && (wrDataChanGrant == GRANT_M0);
  assign pop1 = wrLastDone && (wrDataChanGrant == GRANT_M1);

  always_comb begin
    // While a master's accept pulse is high it is still presenting the old request,
    // so it must not be granted again in that cycle.
    elig0      = AWVALID_M0 && !full0 && !AWREADY_M0;
    elig1      = AWVALID_M1 && !full1 && !AWREADY_M1;
    slv_hs     = |(awvalid_s & {AWREADY_S3, AWREADY_S2, AWREADY_S1, AWREADY_S0});
    state_next = state;
    load0      = 1'b0;
    load1      = 1'b0;
    push0      = 1'b0;
    push1      = 1'b0;
    case (state)
      M0_PRI_IDLE: begin
        if (elig0) begin
          state_next = M0_ISSUE;
          load0      = 1'b1;
        end else if (elig1) begin
          state_next = M1_ISSUE;
          load1      = 1'b1;
        end
      end
      M1_PRI_IDLE: begin
        if (elig1) begin
          state_next = M1_ISSUE;
          load1      = 1'b1;
        end else if (elig0) begin
          state_next = M0_ISSUE;
          load0      = 1'b1;
        end
      end
      // After a handshake priority passes to the other master.
      M0_ISSUE: begin
        if (slv_hs) begin
          state_next = M1_PRI_IDLE;
          push0      = 1'b1;
        end
      end
      M1_ISSUE: begin
        if (slv_hs) begin
          state_next = M0_PRI_IDLE;
          push1      = 1'b1;
        end
      end
      default: state_next = M0_PRI_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= M0_PRI_IDLE;
      awvalid_s  <= '0;
      AWADDR_S   <= '0;
      AWLEN_S    <= '0;
      AWREADY_M0 <= 1'b0;
      AWREADY_M1 <= 1'b0;
    end else begin
      state      <= state_next;
      AWREADY_M0 <= push0;
      AWREADY_M1 <= push1;
      if (load0) begin
        AWADDR_S  <= AWADDR_M0;
        AWLEN_S   <= AWLEN_M0;
        awvalid_s <= slave_onehot(sel0);
      end else if (load1) begin
        AWADDR_S  <= AWADDR_M1;
        AWLEN_S   <= AWLEN_M1;
        awvalid_s <= slave_onehot(sel1);
      end else if (slv_hs) begin
        awvalid_s <= '0;
      end
    end
  end

  axi4_ic_addr_fifo #(.WIDTH(AWIDTH), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clock     (clock),
    .resetn    (resetn),
    .push      (push0),
    .push_data (AWADDR_S),
    .pop       (pop0),
    .full      (full0),
    .empty     (empty0),
    .head      (head0)
  );

  axi4_ic_addr_fifo #(.WIDTH(AWIDTH), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clock     (clock),
    .resetn    (resetn),
    .push      (push1),
    .push_data (AWADDR_S),
    .pop       (pop1),
    .full      (full1),
    .empty     (empty1),
    .head      (head1)
  );

  always_comb begin
    wrDataChanAddr = '0;
    if (wrDataChanGrant == GRANT_M0 && !empty0)      wrDataChanAddr = head0;
    else if (wrDataChanGrant == GRANT_M1 && !empty1) wrDataChanAddr = head1;
  end

endmodule

// File: tb/tb_axi4_interconnect_wr_addr_arbiter.sv
// tb/tb_axi4_interconnect_wr_addr_arbiter.sv - directed self-checking bench for the AW arbiter
module tb_axi4_interconnect_wr_addr_arbiter;

  logic        clock = 1'b0;
  logic        resetn;
  logic        awvalid_m0, awvalid_m1;
  logic [31:0] awaddr_m0, awaddr_m1;
  logic [7:0]  awlen_m0, awlen_m1;
  logic        awready_m0, awready_m1;
  wire  [3:0]  awvalid_s;
  logic [31:0] awaddr_s;
  logic [7:0]  awlen_s;
  logic [3:0]  awready_s;
  logic [1:0]  grant;
  logic        last_done;
  logic [31:0] data_addr;

  int n_checks;
  int n_pass;

  always #5 clock = ~clock;

  axi4_interconnect_wr_addr_arbiter #(.AWIDTH(32), .FIFO_DEPTH(4)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .AWVALID_M0      (awvalid_m0),
    .AWADDR_M0       (awaddr_m0),
    .AWLEN_M0        (awlen_m0),
    .AWREADY_M0      (awready_m0),
    .AWVALID_M1      (awvalid_m1),
    .AWADDR_M1       (awaddr_m1),
    .AWLEN_M1        (awlen_m1),
    .AWREADY_M1      (awready_m1),
    .AWVALID_S0      (awvalid_s[0]),
    .AWVALID_S1      (awvalid_s[1]),
    .AWVALID_S2      (awvalid_s[2]),
    .AWVALID_S3      (awvalid_s[3]),
    .AWADDR_S        (awaddr_s),
    .AWLEN_S         (awlen_s),
    .AWREADY_S0      (awready_s[0]),
    .AWREADY_S1      (awready_s[1]),
    .AWREADY_S2      (awready_s[2]),
    .AWREADY_S3      (awready_s[3]),
    .wrDataChanGrant (grant),
    .wrLastDone      (last_done),
    .wrDataChanAddr  (data_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    resetn     = 1'b0;
    awvalid_m0 = 1'b0; awaddr_m0 = '0; awlen_m0 = '0;
    awvalid_m1 = 1'b0; awaddr_m1 = '0; awlen_m1 = '0;
    awready_s  = '0;
    grant      = '0;
    last_done  = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // Reset state
    apply_reset();
    check("rst_vs",    32'(awvalid_s), 32'h0);
    check("rst_rdy0",  32'(awready_m0), 32'h0);
    check("rst_rdy1",  32'(awready_m1), 32'h0);
    check("rst_addr",  awaddr_s, 32'h0);
    check("rst_len",   32'(awlen_s), 32'h0);
    check("rst_daddr", data_addr, 32'h0);
    check("rst_state", 32'(dut.state), 32'h1);

    // 1: single M0 request to slave 1
    awvalid_m0 = 1'b1; awaddr_m0 = 32'h4000_0010; awlen_m0 = 8'd3;
    tick();
    check("t1_vs",    32'(awvalid_s), 32'h2);
    check("t1_addr",  awaddr_s, 32'h4000_0010);
    check("t1_len",   32'(awlen_s), 32'd3);
    check("t1_rdy_e", 32'(awready_m0), 32'h0);
    tick();
    check("t1_hold_vs",   32'(awvalid_s), 32'h2);
    check("t1_hold_addr", awaddr_s, 32'h4000_0010);
    awready_s = 4'b0010;
    tick();
    check("t1_rdy0",   32'(awready_m0), 32'h1);
    check("t1_vs_clr", 32'(awvalid_s), 32'h0);
    awvalid_m0 = 1'b0; awready_s = '0;
    tick();
    check("t1_rdy0_end", 32'(awready_m0), 32'h0);
    grant = 2'b01; #1;
    check("t1_head0", data_addr, 32'h4000_0010);
    grant = 2'b10; #1;
    check("t1_head1_empty", data_addr, 32'h0);
    grant = 2'b11; #1;
    check("t1_grant11", data_addr, 32'h0);
    grant = 2'b01; last_done = 1'b1;
    tick();
    last_done = 1'b0;
    check("t1_popped", data_addr, 32'h0);

    // 2: both masters valid, alternating service
    apply_reset();
    awready_s  = 4'hF;
    awvalid_m0 = 1'b1; awaddr_m0 = 32'h0000_0100; awlen_m0 = 8'd1;
    awvalid_m1 = 1'b1; awaddr_m1 = 32'hC000_0200; awlen_m1 = 8'd2;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t2_vs",   32'(awvalid_s), (k % 4 == 0) ? 32'h1 : (k % 4 == 2) ? 32'h8 : 32'h0);
      check("t2_rdy0", 32'(awready_m0), (k % 4 == 1) ? 32'h1 : 32'h0);
      check("t2_rdy1", 32'(awready_m1), (k % 4 == 3) ? 32'h1 : 32'h0);
      if (k % 4 == 0) check("t2_addr0", awaddr_s, 32'h0000_0100);
      if (k % 4 == 2) check("t2_addr1", awaddr_s, 32'hC000_0200);
    end
    awvalid_m0 = 1'b0; awvalid_m1 = 1'b0; awready_s = '0;
    grant = 2'b01; #1;
    check("t2_head0", data_addr, 32'h0000_0100);
    grant = 2'b10; #1;
    check("t2_head1", data_addr, 32'hC000_0200);

    // 3: FIFO_0 fills, M0 stalls, M1 still served, a pop releases M0
    apply_reset();
    awready_s  = 4'hF;
    awvalid_m0 = 1'b1; awaddr_m0 = 32'h8000_0000;
    for (int k = 1; k <= 14; k++) begin
      tick();
      check("t3_vs",   32'(awvalid_s), (k % 3 == 1 && k <= 10) ? 32'h4 : 32'h0);
      check("t3_rdy0", 32'(awready_m0), (k % 3 == 2 && k <= 11) ? 32'h1 : 32'h0);
      if (k % 3 == 1 && k <= 10) check("t3_addr", awaddr_s, 32'h8000_0000 + 32'((k - 1) / 3) * 32'h10);
      if (k % 3 == 2 && k <= 11) awaddr_m0 = awaddr_m0 + 32'h10;
    end
    check("t3_count_full", 32'(dut.u_fifo0.count), 32'd4);
    awvalid_m1 = 1'b1; awaddr_m1 = 32'hC000_0040;
    tick();
    check("t3_m1_vs", 32'(awvalid_s), 32'h8);
    tick();
    check("t3_m1_rdy", 32'(awready_m1), 32'h1);
    awvalid_m1 = 1'b0;
    tick();
    check("t3_stall_vs", 32'(awvalid_s), 32'h0);
    grant = 2'b01; #1;
    check("t3_head", data_addr, 32'h8000_0000);
    last_done = 1'b1;
    tick();
    last_done = 1'b0;
    check("t3_pop_vs", 32'(awvalid_s), 32'h0);
    check("t3_pop_head", data_addr, 32'h8000_0010);
    tick();
    check("t3_m0_resume_vs", 32'(awvalid_s), 32'h4);
    check("t3_m0_resume_addr", awaddr_s, 32'h8000_0040);
    tick();
    check("t3_m0_resume_rdy", 32'(awready_m0), 32'h1);
    awvalid_m0 = 1'b0; awready_s = '0; grant = '0;

    // 4: simultaneous push and pop on FIFO_1 at count 2
    apply_reset();
    awready_s  = 4'hF;
    grant      = 2'b10;
    awvalid_m1 = 1'b1; awaddr_m1 = 32'hC000_0100;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("t4_vs",   32'(awvalid_s), (k % 3 == 1) ? 32'h8 : 32'h0);
      check("t4_rdy1", 32'(awready_m1), (k % 3 == 2) ? 32'h1 : 32'h0);
      if (k == 2) awaddr_m1 = 32'hC000_0200;
      if (k == 5) awaddr_m1 = 32'hC000_0300;
      if (k == 7) begin
        check("t4_pre_count", 32'(dut.u_fifo1.count), 32'd2);
        check("t4_pre_head",  data_addr, 32'hC000_0100);
        last_done = 1'b1;
      end
    end
    awvalid_m1 = 1'b0;
    last_done  = 1'b0;
    check("t4_count", 32'(dut.u_fifo1.count), 32'd2);
    check("t4_head",  data_addr, 32'hC000_0200);
    last_done = 1'b1;
    tick();
    check("t4_pop_head",  data_addr, 32'hC000_0300);
    check("t4_pop_count", 32'(dut.u_fifo1.count), 32'd1);
    tick();
    last_done = 1'b0;
    check("t4_empty_head",  data_addr, 32'h0);
    check("t4_empty_count", 32'(dut.u_fifo1.count), 32'd0);
    awready_s = '0; grant = '0;

    // 5: reset mid-operation with a pending slave request
    apply_reset();
    awready_s  = 4'h4;
    grant      = 2'b01;
    awvalid_m0 = 1'b1; awaddr_m0 = 32'h8000_0000;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k % 3 == 2) awaddr_m0 = awaddr_m0 + 32'h10;
      if (k == 8) awready_s = '0;
    end
    check("t5_pre_vs",    32'(awvalid_s), 32'h4);
    check("t5_pre_count", 32'(dut.u_fifo0.count), 32'd3);
    check("t5_pre_head",  data_addr, 32'h8000_0000);
    #2;
    resetn = 1'b0;
    #1;
    check("t5_rst_vs",    32'(awvalid_s), 32'h0);
    check("t5_rst_rdy0",  32'(awready_m0), 32'h0);
    check("t5_rst_addr",  awaddr_s, 32'h0);
    check("t5_rst_daddr", data_addr, 32'h0);
    check("t5_rst_count", 32'(dut.u_fifo0.count), 32'd0);
    awvalid_m0 = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_post_rdy0", 32'(awready_m0), 32'h0);
      check("t5_post_rdy1", 32'(awready_m1), 32'h0);
    end
    check("t5_post_daddr", data_addr, 32'h0);
    check("t5_post_state", 32'(dut.state), 32'h1);
    awvalid_m0 = 1'b1; awaddr_m0 = 32'h8000_0000;
    awvalid_m1 = 1'b1; awaddr_m1 = 32'hC000_0000;
    tick();
    check("t5_m0_prio", 32'(awvalid_s), 32'h4);
    awvalid_m0 = 1'b0; awvalid_m1 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
